// File: rtl/uart_pkg.sv
// uart_pkg: register map, CON bit positions and receiver FSM encoding
// shared by the UART receive peripheral and its bench.
package uart_pkg;
    localparam logic [31:0] RXD_ADDR = 32'h4000_001C;
    localparam logic [31:0] CON_ADDR = 32'h4000_0020;
    localparam int CON_IE    = 0;
    localparam int CON_AVAIL = 1;
    localparam int CON_OVR   = 2;
    localparam int CON_FERR  = 3;
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_WAIT_HIGH} rx_state_t;
endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: power-of-two receive FIFO; push on full is dropped unless a pop
// frees a slot in the same cycle, pop on empty is ignored.
module uart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             sysclk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wp_q, wp_d, rp_q, rp_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    always_comb begin
        empty   = wp_q == rp_q;
        full    = wp_q == {~rp_q[AW], rp_q[AW-1:0]};
        do_pop  = pop & ~empty;
        do_push = push & (~full | do_pop);
        wp_d    = do_push ? wp_q + 1'b1 : wp_q;
        rp_d    = do_pop ? rp_q + 1'b1 : rp_q;
        head    = mem_q[rp_q[AW-1:0]];
    end

    always_ff @(posedge sysclk or negedge reset)
        if (!reset) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            wp_q <= wp_d;
            rp_q <= rp_d;
        end

    always_ff @(posedge sysclk)
        if (do_push) mem_q[wp_q[AW-1:0]] <= din;
endmodule

// File: rtl/uart_rx_periph.sv
// uart_rx_periph: 16x-oversampled UART receiver with RX FIFO, RXD/CON bus
// registers and a level interrupt on data available.
module uart_rx_periph
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 100000000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        sysclk,
    input  logic        reset,
    input  logic        rx,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);
    localparam int DIV = CLK_HZ / (BAUD * 16);
    localparam int DW  = DIV > 1 ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    logic [1:0]    sync_q, sync_d, vld_q, vld_d;
    logic          prev_q, prev_d, rd_q, rd_d, ie_q, ie_d;
    logic          ovr_q, ovr_d, ferr_q, ferr_d, irq_q, irq_d;
    logic [DW-1:0] div_q, div_d;
    rx_state_t     state_q;
    logic [3:0]    tcnt_q;
    logic [2:0]    bcnt_q;
    logic [7:0]    sh_q, head;
    logic          rx_s, fall, tick, stop_smp, push, pop, full, empty, rd_hit, wr_con;
    logic [31:0]   con_w;
    logic          unused_ok;

    // prev only goes high once the sync chain holds real line samples, so a
    // line already low at reset release is not mistaken for a start bit.
    always_comb begin
        rx_s     = sync_q[1];
        fall     = prev_q & ~rx_s;
        tick     = div_q == DIV_LAST;
        stop_smp = state_q == S_STOP && tick && tcnt_q == 4'd15;
        push     = stop_smp & rx_s;
        rd_hit   = rd_en && addr == RXD_ADDR;
        pop      = rd_hit & ~rd_q;
        wr_con   = wr_en && addr == CON_ADDR;
        sync_d   = {sync_q[0], rx};
        vld_d    = {vld_q[0], 1'b1};
        prev_d   = rx_s & vld_q[1];
        div_d    = (tick || (state_q == S_IDLE && fall)) ? '0 : div_q + 1'b1;
        rd_d     = rd_hit;
        ie_d     = wr_con ? wdata[CON_IE] : ie_q;
        ovr_d    = (push & full & ~pop) | (ovr_q & ~(wr_con & wdata[CON_OVR]));
        ferr_d   = (stop_smp & ~rx_s) | (ferr_q & ~(wr_con & wdata[CON_FERR]));
        irq_d    = ie_q & ~empty;
        con_w    = '0;
        con_w[CON_IE]    = ie_q;
        con_w[CON_AVAIL] = ~empty;
        con_w[CON_OVR]   = ovr_q;
        con_w[CON_FERR]  = ferr_q;
        rdata = !rd_en ? '0 :
                addr == RXD_ADDR ? {24'd0, empty ? 8'd0 : head} :
                addr == CON_ADDR ? con_w : '0;
        unused_ok = ^{wdata[31:4], wdata[CON_AVAIL]};
    end

    assign irq = irq_q;

    always_ff @(posedge sysclk or negedge reset)
        if (!reset) begin
            sync_q <= '1;
            vld_q  <= '0;
            prev_q <= 1'b0;
            div_q  <= '0;
            rd_q   <= 1'b0;
            ie_q   <= 1'b0;
            ovr_q  <= 1'b0;
            ferr_q <= 1'b0;
            irq_q  <= 1'b0;
        end else begin
            sync_q <= sync_d;
            vld_q  <= vld_d;
            prev_q <= prev_d;
            div_q  <= div_d;
            rd_q   <= rd_d;
            ie_q   <= ie_d;
            ovr_q  <= ovr_d;
            ferr_q <= ferr_d;
            irq_q  <= irq_d;
        end

    always_ff @(posedge sysclk or negedge reset)
        if (!reset) begin
            state_q <= S_IDLE;
            tcnt_q  <= '0;
            bcnt_q  <= '0;
            sh_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (fall) begin
                    state_q <= S_START;
                    tcnt_q  <= '0;
                end
                S_START: if (tick) begin
                    tcnt_q <= tcnt_q + 1'b1;
                    if (tcnt_q == 4'd7) begin
                        tcnt_q  <= '0;
                        bcnt_q  <= '0;
                        state_q <= rx_s ? S_IDLE : S_DATA;
                    end
                end
                S_DATA: if (tick) begin
                    tcnt_q <= tcnt_q + 1'b1;
                    if (tcnt_q == 4'd15) begin
                        sh_q   <= {rx_s, sh_q[7:1]};
                        bcnt_q <= bcnt_q + 1'b1;
                        if (bcnt_q == 3'd7) state_q <= S_STOP;
                    end
                end
                S_STOP: if (tick) begin
                    tcnt_q <= tcnt_q + 1'b1;
                    if (tcnt_q == 4'd15) state_q <= rx_s ? S_IDLE : S_WAIT_HIGH;
                end
                S_WAIT_HIGH: if (rx_s) state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end

    uart_rx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
        .sysclk(sysclk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (sh_q),
        .full  (full),
        .empty (empty),
        .head  (head)
    );
endmodule

// File: tb/tb_uart_rx_periph.sv
// tb_uart_rx_periph: directed frames and bus accesses against hand-computed
// register values (DIV=10, one bit = 160 sysclk cycles).
module tb_uart_rx_periph;
    localparam logic [31:0] RXD = 32'h4000_001C;
    localparam logic [31:0] CON = 32'h4000_0020;

    logic        sysclk = 1'b0, reset = 1'b0, rx = 1'b1, rd_en = 1'b0, wr_en = 1'b0;
    logic [31:0] addr = '0, wdata = '0, rdata;
    logic        irq;
    int          errors = 0, checks = 0;

    uart_rx_periph #(.CLK_HZ(1600000), .BAUD(10000), .FIFO_DEPTH(4)) dut (
        .sysclk(sysclk),
        .reset (reset),
        .rx    (rx),
        .rd_en (rd_en),
        .wr_en (wr_en),
        .addr  (addr),
        .wdata (wdata),
        .rdata (rdata),
        .irq   (irq)
    );

    always #5 sysclk = ~sysclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic bit_time(input logic v);
        rx = v;
        repeat (160) @(posedge sysclk);
    endtask

    // Start bit, 8 data bits LSB first, stop bit; a good frame gets one idle bit after it.
    task automatic send(input logic [7:0] d, input logic stop);
        bit_time(1'b0);
        for (int i = 0; i < 8; i++) bit_time(d[i]);
        bit_time(stop);
        if (stop) bit_time(1'b1);
    endtask

    task automatic bus_read(input logic [31:0] a, input int hold, output logic [31:0] d);
        @(negedge sysclk);
        addr  = a;
        rd_en = 1'b1;
        #1 d = rdata;
        repeat (hold) @(negedge sysclk);
        rd_en = 1'b0;
        addr  = '0;
    endtask

    task automatic read_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d;
        bus_read(a, 1, d);
        check(tag, d, exp);
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge sysclk);
        addr  = a;
        wdata = d;
        wr_en = 1'b1;
        @(negedge sysclk);
        wr_en = 1'b0;
        addr  = '0;
        wdata = '0;
    endtask

    initial begin
        logic [31:0] d;
        repeat (3) @(posedge sysclk);
        read_chk("rst_con", CON, 32'h0);
        read_chk("rst_rxd", RXD, 32'h0);
        check("rst_irq", irq, 1'b0);
        @(negedge sysclk) reset = 1'b1;
        repeat (20) @(posedge sysclk);

        send(8'h55, 1'b1);
        @(negedge sysclk);
        addr = RXD;
        #1 check("rd_en_low", rdata, 32'h0);
        read_chk("unmapped", 32'h4000_0024, 32'h0);
        read_chk("con_55", CON, 32'h2);
        read_chk("rxd_55", RXD, 32'h55);
        read_chk("con_55_empty", CON, 32'h0);

        bus_write(CON, 32'h1);
        @(posedge sysclk) #1 check("irq_no_data", irq, 1'b0);
        read_chk("con_ie", CON, 32'h1);
        send(8'hA3, 1'b1);
        check("irq_a3", irq, 1'b1);
        read_chk("con_a3", CON, 32'h3);
        read_chk("rxd_a3", RXD, 32'hA3);
        check("irq_after_pop", irq, 1'b1);
        @(posedge sysclk) #1 check("irq_cleared", irq, 1'b0);
        bus_write(CON, 32'h0);

        for (int i = 1; i <= 5; i++) send(8'(i), 1'b1);
        read_chk("con_ovr", CON, 32'h6);
        bus_read(RXD, 3, d);
        check("rxd_held_01", d, 32'h01);
        for (int i = 2; i <= 4; i++) read_chk("rxd_fifo", RXD, 32'(i));
        read_chk("rxd_drained", RXD, 32'h0);
        read_chk("con_ovr_only", CON, 32'h4);
        bus_write(CON, 32'h0);
        read_chk("ovr_kept", CON, 32'h4);
        bus_write(CON, 32'h4);
        read_chk("ovr_w1c", CON, 32'h0);

        send(8'h7E, 1'b0);
        repeat (300) @(posedge sysclk);
        read_chk("con_ferr", CON, 32'h8);
        rx = 1'b1;
        repeat (200) @(posedge sysclk);
        send(8'h11, 1'b1);
        read_chk("rxd_11", RXD, 32'h11);
        read_chk("ferr_kept", CON, 32'h8);
        bus_write(CON, 32'h8);
        read_chk("ferr_w1c", CON, 32'h0);

        rx = 1'b0;
        repeat (40) @(posedge sysclk);
        rx = 1'b1;
        repeat (400) @(posedge sysclk);
        read_chk("glitch_con", CON, 32'h0);
        send(8'h3C, 1'b1);
        read_chk("after_glitch", CON, 32'h2);
        bus_write(CON, 32'h1);
        repeat (2) @(posedge sysclk);
        #1 check("irq_3c", irq, 1'b1);

        // Reset lands in data bit 2 of 0x99 (a zero), line stays low past release.
        bit_time(1'b0);
        bit_time(1'b1);
        bit_time(1'b0);
        rx = 1'b0;
        repeat (80) @(posedge sysclk);
        #2 reset = 1'b0;
        repeat (5) @(posedge sysclk);
        read_chk("mid_rst_con", CON, 32'h0);
        check("mid_rst_irq", irq, 1'b0);
        @(negedge sysclk) reset = 1'b1;
        repeat (200) @(posedge sysclk);
        rx = 1'b1;
        repeat (2000) @(posedge sysclk);
        read_chk("post_rst_con", CON, 32'h0);
        send(8'h42, 1'b1);
        read_chk("rxd_42", RXD, 32'h42);
        read_chk("con_final", CON, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
